mcu_fsm_hs: RTL and testbench

- Registered multi-cycle MIPS control unit with an internal state register.
- Adds handshakes for variable-latency memory (mem_ready) and a multi-cycle mult/div unit (md_start/md_done).
- Adds a timeout watchdog, an illegal-instruction trap and a retired-instruction counter.
- Sits between instruction-register fields and the multi-cycle datapath muxes and enables.

---
 rtl/mcu_pkg.sv | 87 ++++++++
 rtl/mcu_watchdog.sv | 44 ++++
 rtl/mcu_fsm_hs.sv | 214 +++++++++++++++++++++
 tb/tb_mcu_fsm_hs.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared encodings for the handshaked multi-cycle MIPS control unit:
// state numbering, opcode/funct constants, mux selects and trap causes.
package mcu_pkg;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_EXEC    = 4'd6,
      S_RWB     = 4'd7,
      S_BRANCH  = 4'd8,
      S_JUMP    = 4'd9,
      S_SHEXEC  = 4'd10,
      S_MDSTART = 4'd11,
      S_MDWAIT  = 4'd12,
      S_JR      = 4'd13,
      S_JAL     = 4'd14,
      S_TRAP    = 4'd15
   } state_t;

   localparam logic [5:0] OP_RTYPE  = 6'b000000;
   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_J      = 6'b000010;
   localparam logic [5:0] OP_JAL    = 6'b000011;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;
   localparam logic [5:0] OP_LW     = 6'b100011;
   localparam logic [5:0] OP_SW     = 6'b101011;
   localparam logic [5:0] FN_JR     = 6'b001000;

   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_A     = 2'b01;
   localparam logic [1:0] SRCA_SHAMT = 2'b10;

   localparam logic [2:0] SRCB_B      = 3'b000;
   localparam logic [2:0] SRCB_FOUR   = 3'b001;
   localparam logic [2:0] SRCB_IMM    = 3'b010;
   localparam logic [2:0] SRCB_IMM_SH = 3'b011;
   localparam logic [2:0] SRCB_ZERO   = 3'b100;

   localparam logic [1:0] PC_ALU    = 2'b00;
   localparam logic [1:0] PC_ALUOUT = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_A      = 2'b11;

   localparam logic [1:0] RD_RT  = 2'b00;
   localparam logic [1:0] RD_RD  = 2'b01;
   localparam logic [1:0] RD_R31 = 2'b10;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_BR  = 2'b01;
   localparam logic [1:0] ALU_FN  = 2'b10;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_BUS     = 2'b10;
   localparam logic [1:0] CAUSE_MD      = 2'b11;

   // Variable shifts (0001xx) take their amount from rs, so they go through EXEC
   // rather than the shamt path used by the other 000xxx functs.
   function automatic state_t decode_next(input logic [5:0] op, input logic [5:0] fn,
                                          input logic muldiv_en);
      state_t ns;
      ns = S_TRAP;
      case (op)
         OP_LW, OP_SW: ns = S_MEMADR;
         OP_RTYPE: begin
            if (fn[5:2] == 4'b0001)      ns = S_EXEC;
            else if (fn[5:3] == 3'b000)  ns = S_SHEXEC;
            else if (fn == FN_JR)        ns = S_JR;
            else if (fn[5:4] == 2'b10)   ns = S_EXEC;
            else if (fn[5:3] == 3'b011)  ns = muldiv_en ? S_MDSTART : S_TRAP;
         end
         OP_J:   ns = S_JUMP;
         OP_JAL: ns = S_JAL;
         OP_BEQ, OP_BNE, OP_REGIMM, OP_BLEZ, OP_BGTZ: ns = S_BRANCH;
         default: ns = S_TRAP;
      endcase
      return ns;
   endfunction

endpackage

// File: rtl/mcu_watchdog.sv
// Handshake watchdog: counts stalled cycles in memory and mult/div wait
// states and flags the cycle in which the stall limit is reached.
module mcu_watchdog
   import mcu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int MD_TIMEOUT  = 64
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   active,
   input  state_t state,
   input  logic   mem_ready,
   input  logic   md_done,
   output logic   mem_timeout,
   output logic   md_timeout
);

   localparam int MAX_TO = (MEM_TIMEOUT > MD_TIMEOUT) ? MEM_TIMEOUT : MD_TIMEOUT;
   localparam int WC_W   = $clog2(MAX_TO);

   logic [WC_W-1:0] wait_cnt;
   logic            mem_wait;
   logic            md_wait;

   assign mem_wait = active && !mem_ready &&
                     (state == S_FETCH || state == S_MEMRD || state == S_MEMWR);
   assign md_wait  = active && !md_done && (state == S_MDWAIT);

   assign mem_timeout = mem_wait && (wait_cnt == WC_W'(MEM_TIMEOUT - 1));
   assign md_timeout  = md_wait  && (wait_cnt == WC_W'(MD_TIMEOUT - 1));

   // Every non-stalled cycle either leaves the state or sits in TRAP, so
   // clearing here is the same as clearing on each state change.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         wait_cnt <= '0;
      else if ((mem_wait && !mem_timeout) || (md_wait && !md_timeout))
         wait_cnt <= wait_cnt + 1'b1;
      else
         wait_cnt <= '0;
   end

endmodule

// File: rtl/mcu_fsm_hs.sv
// Registered multi-cycle MIPS control unit with memory and mult/div
// handshakes, stall watchdog, illegal-instruction trap and retire counter.
module mcu_fsm_hs
   import mcu_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16,
   parameter int MD_TIMEOUT  = 64,
   parameter int MULDIV_EN   = 1,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [5:0]       op_code,
   input  logic [4:0]       b_code,
   input  logic [5:0]       funct,
   input  logic             mem_ready,
   input  logic             md_done,
   output logic             iord,
   output logic             ir_write,
   output logic             pc_write,
   output logic             reg_write,
   output logic             hilo_write,
   output logic             mem_to_reg,
   output logic             mem_read,
   output logic             mem_write,
   output logic             md_start,
   output logic [5:0]       branch,
   output logic [1:0]       reg_dst,
   output logic [1:0]       alu_src_a,
   output logic [2:0]       alu_src_b,
   output logic [1:0]       pc_src,
   output logic [1:0]       alu_op,
   output logic [3:0]       state,
   output logic             trap,
   output logic [1:0]       trap_cause,
   output logic             instr_done,
   output logic [CNT_W-1:0] retire_cnt
);

   state_t     state_q, state_d;
   logic       active;
   logic       trap_q;
   logic [1:0] cause_q, cause_d;
   logic       retire;
   logic       mem_to, md_to;

   mcu_watchdog #(
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .MD_TIMEOUT  (MD_TIMEOUT)
   ) u_watchdog (
      .clk         (clk),
      .rst_n       (rst_n),
      .active      (active),
      .state       (state_q),
      .mem_ready   (mem_ready),
      .md_done     (md_done),
      .mem_timeout (mem_to),
      .md_timeout  (md_to)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_FETCH;
         active     <= 1'b0;
         trap_q     <= 1'b0;
         cause_q    <= CAUSE_NONE;
         retire_cnt <= '0;
      end else begin
         active  <= 1'b1;
         state_q <= state_d;
         if (state_d == S_TRAP && state_q != S_TRAP) begin
            trap_q  <= 1'b1;
            cause_q <= cause_d;
         end
         if (retire)
            retire_cnt <= retire_cnt + 1'b1;
      end
   end

   always_comb begin
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      hilo_write = 1'b0;
      mem_to_reg = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      md_start   = 1'b0;
      branch     = 6'b000000;
      reg_dst    = RD_RT;
      alu_src_a  = SRCA_PC;
      alu_src_b  = SRCB_B;
      pc_src     = PC_ALU;
      alu_op     = ALU_ADD;
      retire     = 1'b0;
      cause_d    = CAUSE_NONE;
      state_d    = state_q;

      // Outputs stay quiet and the state holds until the first edge after reset.
      if (active) begin
         case (state_q)
            S_FETCH: begin
               mem_read  = 1'b1;
               alu_src_b = SRCB_FOUR;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
               if (mem_ready)   state_d = S_DECODE;
               else if (mem_to) begin state_d = S_TRAP; cause_d = CAUSE_BUS; end
            end
            S_DECODE: begin
               alu_src_b = SRCB_IMM_SH;
               state_d   = decode_next(op_code, funct, MULDIV_EN != 0);
               cause_d   = CAUSE_ILLEGAL;
            end
            S_MEMADR: begin
               alu_src_a = SRCA_A;
               alu_src_b = SRCB_IMM;
               state_d   = (op_code == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
               iord     = 1'b1;
               mem_read = 1'b1;
               if (mem_ready)   state_d = S_MEMWB;
               else if (mem_to) begin state_d = S_TRAP; cause_d = CAUSE_BUS; end
            end
            S_MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               reg_dst    = RD_RT;
               retire     = 1'b1;
            end
            S_MEMWR: begin
               iord      = 1'b1;
               mem_write = 1'b1;
               if (mem_ready)   retire = 1'b1;
               else if (mem_to) begin state_d = S_TRAP; cause_d = CAUSE_BUS; end
            end
            S_EXEC: begin
               alu_src_a = SRCA_A;
               alu_op    = ALU_FN;
               state_d   = S_RWB;
            end
            S_SHEXEC: begin
               alu_src_a = SRCA_SHAMT;
               alu_op    = ALU_FN;
               state_d   = S_RWB;
            end
            S_RWB: begin
               reg_write = 1'b1;
               reg_dst   = RD_RD;
               retire    = 1'b1;
            end
            S_BRANCH: begin
               alu_src_a = SRCA_A;
               alu_op    = ALU_BR;
               pc_src    = PC_ALUOUT;
               alu_src_b = (op_code == OP_BEQ || op_code == OP_BNE) ? SRCB_B : SRCB_ZERO;
               case (op_code)
                  OP_BEQ:    branch = 6'b100000;
                  OP_BNE:    branch = 6'b010000;
                  OP_REGIMM: branch = b_code[0] ? 6'b001000 : 6'b000001;
                  OP_BGTZ:   branch = 6'b000100;
                  OP_BLEZ:   branch = 6'b000010;
                  default:   branch = 6'b000000;
               endcase
               retire = 1'b1;
            end
            S_JUMP: begin
               pc_write = 1'b1;
               pc_src   = PC_JUMP;
               retire   = 1'b1;
            end
            S_JR: begin
               pc_write = 1'b1;
               pc_src   = PC_A;
               retire   = 1'b1;
            end
            S_JAL: begin
               pc_write  = 1'b1;
               pc_src    = PC_JUMP;
               reg_write = 1'b1;
               reg_dst   = RD_R31;
               retire    = 1'b1;
            end
            S_MDSTART: begin
               alu_src_a = SRCA_A;
               alu_op    = ALU_FN;
               md_start  = 1'b1;
               state_d   = S_MDWAIT;
            end
            S_MDWAIT: begin
               alu_op = ALU_FN;
               if (md_done) begin
                  hilo_write = 1'b1;
                  retire     = 1'b1;
               end else if (md_to) begin
                  state_d = S_TRAP;
                  cause_d = CAUSE_MD;
               end
            end
            S_TRAP: state_d = S_TRAP;
         endcase
      end

      if (retire) state_d = S_FETCH;
   end

   assign instr_done = retire;
   assign state      = state_q;
   assign trap       = trap_q;
   assign trap_cause = cause_q;

endmodule

// File: tb/tb_mcu_fsm_hs.sv
// Bench for mcu_fsm_hs: randomized instruction stream with random handshake
// latencies against a path/table model, plus directed trap and reset scenarios.
module tb_mcu_fsm_hs;

   localparam int MEM_TO = 4;
   localparam int MD_TO  = 16;
   localparam int CW     = 4;

   localparam int K_LW = 0, K_SW = 1, K_SH = 2, K_ALU = 3, K_JR = 4,
                  K_J = 5, K_JAL = 6, K_BR = 7, K_MD = 8;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [5:0]    op_code = '0;
   logic [4:0]    b_code = '0;
   logic [5:0]    funct = '0;
   logic          mem_ready = 1'b0;
   logic          md_done = 1'b0;
   logic          iord, ir_write, pc_write, reg_write, hilo_write;
   logic          mem_to_reg, mem_read, mem_write, md_start;
   logic [5:0]    branch;
   logic [1:0]    reg_dst, alu_src_a, pc_src, alu_op, trap_cause;
   logic [2:0]    alu_src_b;
   logic [3:0]    state;
   logic          trap, instr_done;
   logic [CW-1:0] retire_cnt;
   logic [33:0]   got;

   int n_tests = 0;
   int n_fail  = 0;
   int ret_model = 0;

   mcu_fsm_hs #(
      .MEM_TIMEOUT (MEM_TO),
      .MD_TIMEOUT  (MD_TO),
      .MULDIV_EN   (1),
      .CNT_W       (CW)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .op_code    (op_code),
      .b_code     (b_code),
      .funct      (funct),
      .mem_ready  (mem_ready),
      .md_done    (md_done),
      .iord       (iord),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .reg_write  (reg_write),
      .hilo_write (hilo_write),
      .mem_to_reg (mem_to_reg),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .md_start   (md_start),
      .branch     (branch),
      .reg_dst    (reg_dst),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .pc_src     (pc_src),
      .alu_op     (alu_op),
      .state      (state),
      .trap       (trap),
      .trap_cause (trap_cause),
      .instr_done (instr_done),
      .retire_cnt (retire_cnt)
   );

   always #5 clk = ~clk;

   assign got = {iord, ir_write, pc_write, reg_write, hilo_write, mem_to_reg, mem_read,
                 mem_write, md_start, branch, reg_dst, alu_src_a, alu_src_b, pc_src,
                 alu_op, trap, trap_cause, instr_done, state};

   // Control word required in a given state, straight from the state table.
   function automatic logic [33:0] expect_out(input int st, input logic [5:0] op,
                                              input logic [4:0] bc, input logic mr,
                                              input logic md, input logic last);
      logic io, irw, pcw, rw, hw, m2r, mrd, mwr, mds;
      logic [5:0] br;
      logic [1:0] rdst, sa, pcs, aop;
      logic [2:0] sb;
      logic [3:0] st4;
      {io, irw, pcw, rw, hw, m2r, mrd, mwr, mds} = '0;
      br = '0; rdst = '0; sa = '0; pcs = '0; aop = '0; sb = '0;
      st4 = st[3:0];
      case (st)
         0:  begin mrd = 1; sb = 3'd1; irw = mr; pcw = mr; end
         1:  sb = 3'd3;
         2:  begin sa = 2'd1; sb = 3'd2; end
         3:  begin io = 1; mrd = 1; end
         4:  begin rw = 1; m2r = 1; rdst = 2'd0; end
         5:  begin io = 1; mwr = 1; end
         6:  begin sa = 2'd1; aop = 2'd2; end
         7:  begin rw = 1; rdst = 2'd1; end
         8:  begin
            sa = 2'd1; aop = 2'd1; pcs = 2'd1;
            sb = (op == 6'd4 || op == 6'd5) ? 3'd0 : 3'd4;
            if (op == 6'd4)      br = 6'b100000;
            else if (op == 6'd5) br = 6'b010000;
            else if (op == 6'd1) br = bc[0] ? 6'b001000 : 6'b000001;
            else if (op == 6'd7) br = 6'b000100;
            else if (op == 6'd6) br = 6'b000010;
         end
         9:  begin pcw = 1; pcs = 2'd2; end
         10: begin sa = 2'd2; aop = 2'd2; end
         11: begin sa = 2'd1; aop = 2'd2; mds = 1; end
         12: begin aop = 2'd2; hw = md; end
         13: begin pcw = 1; pcs = 2'd3; end
         14: begin pcw = 1; pcs = 2'd2; rw = 1; rdst = 2'd2; end
         default: ;
      endcase
      return {io, irw, pcw, rw, hw, m2r, mrd, mwr, mds, br, rdst, sa, sb, pcs, aop,
              1'b0, 2'b00, last, st4};
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; mem_ready = 1'b0; md_done = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      ret_model = 0;
   endtask

   task automatic step(input logic mr, input logic md);
      @(negedge clk);
      mem_ready = mr; md_done = md;
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction along the path its class takes, with the given
   // stall counts in FETCH, the memory state and MDWAIT.
   task automatic run_instr(input logic [5:0] op, input logic [4:0] bc, input logic [5:0] fn,
                            input int kind, input int fl, input int ml, input int dl,
                            input string name);
      int st_q[$];
      bit hs_q[$];
      logic [33:0] exp;
      op_code = op; b_code = bc; funct = fn;
      for (int k = 0; k < fl; k++) begin st_q.push_back(0); hs_q.push_back(0); end
      st_q.push_back(0); hs_q.push_back(1);
      st_q.push_back(1); hs_q.push_back(0);
      case (kind)
         K_LW: begin
            st_q.push_back(2); hs_q.push_back(0);
            for (int k = 0; k < ml; k++) begin st_q.push_back(3); hs_q.push_back(0); end
            st_q.push_back(3); hs_q.push_back(1);
            st_q.push_back(4); hs_q.push_back(0);
         end
         K_SW: begin
            st_q.push_back(2); hs_q.push_back(0);
            for (int k = 0; k < ml; k++) begin st_q.push_back(5); hs_q.push_back(0); end
            st_q.push_back(5); hs_q.push_back(1);
         end
         K_SH:  begin st_q.push_back(10); hs_q.push_back(0); st_q.push_back(7); hs_q.push_back(0); end
         K_ALU: begin st_q.push_back(6);  hs_q.push_back(0); st_q.push_back(7); hs_q.push_back(0); end
         K_JR:  begin st_q.push_back(13); hs_q.push_back(0); end
         K_J:   begin st_q.push_back(9);  hs_q.push_back(0); end
         K_JAL: begin st_q.push_back(14); hs_q.push_back(0); end
         K_BR:  begin st_q.push_back(8);  hs_q.push_back(0); end
         default: begin
            st_q.push_back(11); hs_q.push_back(0);
            for (int k = 0; k < dl; k++) begin st_q.push_back(12); hs_q.push_back(0); end
            st_q.push_back(12); hs_q.push_back(1);
         end
      endcase
      for (int i = 0; i < st_q.size(); i++) begin
         @(negedge clk);
         if (st_q[i] == 0 || st_q[i] == 3 || st_q[i] == 5) begin
            mem_ready = hs_q[i]; md_done = 1'b0;
         end else if (st_q[i] == 12) begin
            md_done = hs_q[i]; mem_ready = 1'($urandom);
         end else begin
            mem_ready = 1'($urandom); md_done = 1'b0;
         end
         #1;
         exp = expect_out(st_q[i], op, bc, mem_ready, md_done, i == st_q.size() - 1);
         n_tests++;
         if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h required %h", name, i, got, exp);
         end
      end
      @(posedge clk);
      #1;
      ret_model = (ret_model + 1) % (1 << CW);
      n_tests++;
      if (retire_cnt !== CW'(ret_model)) begin
         n_fail++;
         $display("FAIL %s retire_cnt: got %0d required %0d", name, retire_cnt, ret_model);
      end
   endtask

   task automatic run_random(input string name);
      int kind;
      logic [5:0] op, fn;
      logic [4:0] bc;
      kind = $urandom_range(0, 8);
      op = 6'd0; fn = 6'd0; bc = 5'($urandom);
      case (kind)
         K_LW:  op = 6'b100011;
         K_SW:  op = 6'b101011;
         K_SH:  fn = {4'b0000, 2'($urandom)};
         K_ALU: fn = {2'b10, 4'($urandom)};
         K_JR:  fn = 6'b001000;
         K_J:   op = 6'b000010;
         K_JAL: op = 6'b000011;
         K_BR: begin
            case ($urandom_range(0, 4))
               0: op = 6'd4;
               1: op = 6'd5;
               2: op = 6'd1;
               3: op = 6'd6;
               default: op = 6'd7;
            endcase
         end
         default: fn = {3'b011, 3'($urandom)};
      endcase
      run_instr(op, bc, fn, kind, $urandom_range(0, MEM_TO - 1),
                $urandom_range(0, MEM_TO - 1), $urandom_range(0, MD_TO - 1), name);
   endtask

   task automatic test_reset();
      rst_n = 1'b0; mem_ready = 1'b1;
      @(negedge clk);
      #1;
      n_tests++;
      if (got !== 34'h0 || retire_cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_hold: got %h cnt %0d required 0", got, retire_cnt);
      end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_tests++;
      if (got !== 34'h0) begin
         n_fail++;
         $display("FAIL reset_inactive: got %h required 0", got);
      end
      mem_ready = 1'b0;
      @(posedge clk);
      #1;
      n_tests++;
      if (got !== expect_out(0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0)) begin
         n_fail++;
         $display("FAIL reset_first_fetch: got %h required %h", got,
                  expect_out(0, 6'd0, 5'd0, 1'b0, 1'b0, 1'b0));
      end
      ret_model = 0;
   endtask

   task automatic test_directed();
      run_instr(6'b000000, 5'd0, 6'b100000, K_ALU, 0, 0, 0, "add");
      run_instr(6'b100011, 5'd0, 6'd0, K_LW, 0, 3, 0, "lw_wait3");
      run_instr(6'b000000, 5'd0, 6'b100000, K_ALU, MEM_TO - 1, 0, 0, "fetch_ready_last");
      run_instr(6'b000001, 5'b00001, 6'd0, K_BR, 0, 0, 0, "bgez");
      run_instr(6'b000001, 5'b00000, 6'd0, K_BR, 0, 0, 0, "bltz");
      run_instr(6'b000100, 5'd0, 6'd0, K_BR, 0, 0, 0, "beq");
      run_instr(6'b000000, 5'd0, 6'b011000, K_MD, 0, 0, 10, "mult");
      run_instr(6'b000000, 5'd0, 6'b000000, K_SH, 1, 0, 0, "sll");
      run_instr(6'b000011, 5'd0, 6'd0, K_JAL, 0, 0, 0, "jal");
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++) run_random("random");
   endtask

   task automatic test_fetch_timeout();
      do_reset();
      repeat (MEM_TO - 1) step(1'b0, 1'b0);
      n_tests++;
      if (state !== 4'd0 || trap !== 1'b0) begin
         n_fail++;
         $display("FAIL fetch_pre_timeout: state %0d trap %b required 0 0", state, trap);
      end
      step(1'b0, 1'b0);
      n_tests++;
      if (state !== 4'd15 || trap !== 1'b1 || trap_cause !== 2'b10) begin
         n_fail++;
         $display("FAIL fetch_timeout: state %0d trap %b cause %b required 15 1 10",
                  state, trap, trap_cause);
      end
      repeat (3) step(1'b1, 1'b1);
      n_tests++;
      if (got !== {27'd0, 1'b1, 2'b10, 1'b0, 4'd15} || retire_cnt !== '0) begin
         n_fail++;
         $display("FAIL trap_sticky: got %h cnt %0d required %h 0", got, retire_cnt,
                  {27'd0, 1'b1, 2'b10, 1'b0, 4'd15});
      end
   endtask

   task automatic test_illegal();
      do_reset();
      op_code = 6'b111111; funct = 6'd0;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      n_tests++;
      if (state !== 4'd15 || trap !== 1'b1 || trap_cause !== 2'b01) begin
         n_fail++;
         $display("FAIL illegal_op: state %0d trap %b cause %b required 15 1 01",
                  state, trap, trap_cause);
      end
   endtask

   task automatic test_md_timeout();
      do_reset();
      op_code = 6'd0; funct = 6'b011010;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      repeat (MD_TO - 1) step(1'b0, 1'b0);
      n_tests++;
      if (state !== 4'd12 || trap !== 1'b0) begin
         n_fail++;
         $display("FAIL md_pre_timeout: state %0d trap %b required 12 0", state, trap);
      end
      step(1'b0, 1'b0);
      n_tests++;
      if (state !== 4'd15 || trap_cause !== 2'b11) begin
         n_fail++;
         $display("FAIL md_timeout: state %0d cause %b required 15 11", state, trap_cause);
      end
      step(1'b0, 1'b1);
      n_tests++;
      if (hilo_write !== 1'b0 || instr_done !== 1'b0 || retire_cnt !== '0 || state !== 4'd15) begin
         n_fail++;
         $display("FAIL md_after_trap: hilo %b done %b cnt %0d state %0d required 0 0 0 15",
                  hilo_write, instr_done, retire_cnt, state);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < (1 << CW); i++) run_random("wrap");
      n_tests++;
      if (retire_cnt !== '0) begin
         n_fail++;
         $display("FAIL retire_wrap: got %0d required 0", retire_cnt);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      run_instr(6'b000000, 5'd0, 6'b100101, K_ALU, 0, 0, 0, "or_before_abort");
      op_code = 6'b101011; funct = 6'd0;
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
      n_tests++;
      if (state !== 4'd5 || mem_write !== 1'b1 || retire_cnt !== CW'(1)) begin
         n_fail++;
         $display("FAIL sw_in_memwr: state %0d mem_write %b cnt %0d required 5 1 1",
                  state, mem_write, retire_cnt);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (got !== 34'h0 || retire_cnt !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_memwr: got %h cnt %0d required 0 0", got, retire_cnt);
      end
      do_reset();
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_fetch_timeout();
      test_illegal();
      test_md_timeout();
      test_wrap();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
